// File: rtl/instr_fetch_decode_if.sv
// Fetch/decode bus bundle: instruction-memory read port, PC redirect
// input and the decoded-instruction handoff to the Data stage.
// master = fetch/decode unit, slave = memory / branch / Data-stage side.
interface instr_fetch_decode_if;
  // instruction memory
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  // redirect from branch/jump resolution
  logic        pc_load;
  logic [15:0] pc_target;
  // decoded instruction to the Data stage
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  output_opcode;
  logic [2:0]  output_reg_readA_address;
  logic [2:0]  output_reg_readB_address;
  logic [2:0]  output_reg_write_address;
  logic [15:0] output_imm;
  logic [15:0] output_pc;

  modport master (
    output mem_req, mem_addr,
    input  mem_ready, mem_rdata,
    input  pc_load, pc_target,
    output out_valid,
    input  out_ready,
    output output_opcode, output_reg_readA_address, output_reg_readB_address,
    output output_reg_write_address, output_imm, output_pc
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ready, mem_rdata,
    output pc_load, pc_target,
    input  out_valid,
    output out_ready,
    input  output_opcode, output_reg_readA_address, output_reg_readB_address,
    input  output_reg_write_address, output_imm, output_pc
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage of the 16-bit multi-cycle core.
// IDLE -> FETCH (memory handshake) -> HOLD (offer decoded word) -> FETCH ...
// Redirects that arrive while a read is outstanding are parked in a
// target register; the returning word is then dropped and refetch starts
// from the newest target.
module instr_fetch_decode #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_decode_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rw;
    logic [15:0] imm;
  } dec_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] held_pc;
  logic [15:0] tgt;
  logic        squash;
  logic        req_q;
  logic        vld_q;
  dec_t        dec;

  // Sequencer: state, PC, IR and the registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      held_pc <= 16'h0000;
      tgt     <= 16'h0000;
      squash  <= 1'b0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // memory responses here are stale and ignored
          if (bus.pc_load) pc <= bus.pc_target;
          state <= FETCH;
          req_q <= 1'b1;
          vld_q <= 1'b0;
        end
        FETCH: begin
          if (bus.mem_ready) begin
            if (squash || bus.pc_load) begin
              // drop the word; a same-cycle redirect beats the parked one
              pc     <= bus.pc_load ? bus.pc_target : tgt;
              squash <= 1'b0;
            end else begin
              ir      <= bus.mem_rdata;
              held_pc <= pc;
              pc      <= pc + PC_INC;
              state   <= HOLD;
              req_q   <= 1'b0;
              vld_q   <= 1'b1;
            end
          end else if (bus.pc_load) begin
            // address must not move mid-request, so park the target
            tgt    <= bus.pc_target;
            squash <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.pc_load) begin
            // held instruction is squashed even if out_ready is high
            pc    <= bus.pc_target;
            state <= FETCH;
            req_q <= 1'b1;
            vld_q <= 1'b0;
          end else if (bus.out_ready) begin
            state <= FETCH;
            req_q <= 1'b1;
            vld_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

  // Decode the instruction register into R/I/J-type fields.
  always_comb begin
    dec        = '0;
    dec.opcode = ir[15:12];
    if (ir[15:12] == 4'h0) begin
      dec.ra  = ir[8:6];
      dec.rb  = ir[5:3];
      dec.rw  = ir[11:9];
      dec.imm = 16'h0000;
    end else if (ir[15:12] <= 4'hB) begin
      dec.ra  = ir[8:6];
      dec.rb  = ir[11:9];
      dec.rw  = ir[11:9];
      dec.imm = {{10{ir[5]}}, ir[5:0]};
    end else begin
      dec.ra  = 3'd0;
      dec.rb  = 3'd0;
      dec.rw  = 3'd0;
      dec.imm = {{4{ir[11]}}, ir[11:0]};
    end
  end

  assign bus.mem_req                  = req_q;
  assign bus.mem_addr                 = pc;
  assign bus.out_valid                = vld_q;
  assign bus.output_opcode            = dec.opcode;
  assign bus.output_reg_readA_address = dec.ra;
  assign bus.output_reg_readB_address = dec.rb;
  assign bus.output_reg_write_address = dec.rw;
  assign bus.output_imm               = dec.imm;
  assign bus.output_pc                = held_pc;

endmodule
